// File: rtl/npu_load_ctrl.sv
// npu_load_ctrl: host-to-NPU load controller. It streams image words into
// byte-lane banks and parameter bytes into parameter memory, then sequences
// inference.
// Ports: clk/reset, control_reg command (bits[1:0]), wr_valid/writedata/
// wr_ready host stream, img_* image bank write, par_* parameter byte write,
// infer_start/infer_done datapath handshake, busy/load_done/err_ovf status.
module npu_load_ctrl #(
    parameter int DATA_W      = 32,
    parameter int LANES       = DATA_W / 8,
    parameter int IMG_WORDS   = 224,
    parameter int PARAM_BYTES = 18816,
    parameter int PARAM_PACK  = 1,
    parameter int IMG_AW      = 8,
    parameter int PAR_AW      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       control_reg,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] writedata,
    output logic              wr_ready,
    output logic              img_we,
    output logic [IMG_AW-1:0] img_addr,
    output logic [DATA_W-1:0] img_wdata,
    output logic              par_we,
    output logic [PAR_AW-1:0] par_addr,
    output logic [7:0]        par_wdata,
    output logic              infer_start,
    input  logic              infer_done,
    output logic              busy,
    output logic              load_done,
    output logic              err_ovf
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_IMG = 3'd1;
    localparam logic [2:0] S_LOAD_PAR = 3'd2;
    localparam logic [2:0] S_LOADED   = 3'd3;
    localparam logic [2:0] S_START    = 3'd4;
    localparam logic [2:0] S_RUN      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam int RW = (PARAM_PACK > 1) ? $clog2(PARAM_PACK) : 1;

    logic [2:0]        state;
    logic [1:0]        cmd_q;
    logic              cmd_armed;
    logic [IMG_AW-1:0] img_cnt;
    logic [PAR_AW-1:0] par_cnt;
    logic [DATA_W-1:0] hold_q;
    logic [RW-1:0]     rem_q;
    logic              err_q;

    logic [1:0] cmd;
    logic       cmd_chg;
    logic       go_load;
    logic       go_run;
    logic       go_idle;
    logic       in_img;
    logic       in_par;
    logic       draining;
    logic       img_last;
    logic       par_last;
    logic       no_load;
    logic [7:0] first_byte;
    logic       unused_ctrl;

    assign unused_ctrl = ^control_reg[31:2];

    // cmd_armed keeps the value present at reset release from looking
    // like a fresh command: the first edge only captures it.
    assign cmd     = control_reg[1:0];
    assign cmd_chg = cmd_armed && (cmd != cmd_q);
    assign go_load = cmd_chg && (cmd == 2'b01);
    assign go_run  = cmd_chg && (cmd == 2'b10);
    assign go_idle = cmd_chg && (cmd == 2'b00);

    assign in_img   = (state == S_LOAD_IMG);
    assign in_par   = (state == S_LOAD_PAR);
    // Bytes of a captured packed word still to go out; host is stalled.
    assign draining = in_par && (rem_q != '0);

    assign wr_ready = in_img || (in_par && (rem_q == '0));

    assign img_we   = in_img && wr_valid;
    assign img_addr = img_cnt;
    assign img_last = img_we && (img_cnt == IMG_AW'(IMG_WORDS - 1));

    // Bank 0 takes the most significant byte of the host word.
    always_comb begin
        img_wdata = '0;
        if (img_we) begin
            for (int k = 0; k < LANES; k++) begin
                img_wdata[8*k +: 8] = writedata[8*(LANES-1-k) +: 8];
            end
        end
    end

    assign first_byte = (PARAM_PACK == 1) ? writedata[7:0]
                                          : writedata[DATA_W-1 -: 8];

    // The first byte of a word goes out in its acceptance cycle; the
    // rest come from hold_q on the following cycles.
    assign par_we   = draining || (in_par && wr_valid);
    assign par_addr = par_cnt;
    assign par_last = par_we && (par_cnt == PAR_AW'(PARAM_BYTES - 1));

    always_comb begin
        par_wdata = '0;
        if (draining) begin
            par_wdata = hold_q[DATA_W-1 -: 8];
        end else if (par_we) begin
            par_wdata = first_byte;
        end
    end

    assign infer_start = (state == S_START);
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign load_done   = (state == S_LOADED) || (state == S_START) ||
                         (state == S_RUN)    || (state == S_DONE);
    assign err_ovf     = err_q;

    assign no_load = (state == S_IDLE) || (state == S_LOADED) ||
                     (state == S_RUN)  || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= 2'b00;
            cmd_armed <= 1'b0;
            img_cnt   <= '0;
            par_cnt   <= '0;
            hold_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            cmd_armed <= 1'b1;
            cmd_q     <= cmd;
            if (wr_valid && no_load) begin
                err_q <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (go_load) begin
                        state   <= S_LOAD_IMG;
                        img_cnt <= '0;
                        par_cnt <= '0;
                    end
                end
                S_LOAD_IMG: begin
                    if (go_idle) begin
                        state <= S_IDLE;
                    end else if (img_we) begin
                        if (img_last) begin
                            state <= S_LOAD_PAR;
                        end else begin
                            img_cnt <= img_cnt + IMG_AW'(1);
                        end
                    end
                end
                S_LOAD_PAR: begin
                    if (go_idle) begin
                        state <= S_IDLE;
                        rem_q <= '0;
                    end else if (par_we) begin
                        if (!par_last) begin
                            par_cnt <= par_cnt + PAR_AW'(1);
                        end
                        if (draining) begin
                            hold_q <= hold_q << 8;
                            rem_q  <= rem_q - RW'(1);
                        end else begin
                            hold_q <= writedata << 8;
                            rem_q  <= RW'(PARAM_PACK - 1);
                        end
                        // Trailing bytes of the last packed word are dropped.
                        if (par_last) begin
                            state <= S_LOADED;
                            rem_q <= '0;
                        end
                    end
                end
                S_LOADED: begin
                    if (go_run) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (infer_done) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (go_load) begin
                        state   <= S_LOAD_IMG;
                        img_cnt <= '0;
                        par_cnt <= '0;
                    end else if (go_run) begin
                        state <= S_START;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_load_ctrl.sv
// tb_npu_load_ctrl: randomized self-checking bench for npu_load_ctrl.
// Drives a default instance and a packed-parameter instance.
module tb_npu_load_ctrl;

    localparam int IMGW = 224;
    localparam int PARB = 18816;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // default-parameter instance
    logic        b_rst, b_valid, b_done;
    logic [31:0] b_ctrl, b_wdata;
    logic        b_ready, b_img_we, b_par_we, b_start, b_busy, b_ldone, b_err;
    logic [7:0]  b_img_addr;
    logic [31:0] b_img_wdata;
    logic [14:0] b_par_addr;
    logic [7:0]  b_par_wdata;

    npu_load_ctrl u_big (
        .clk(clk), .reset(b_rst), .control_reg(b_ctrl),
        .wr_valid(b_valid), .writedata(b_wdata), .wr_ready(b_ready),
        .img_we(b_img_we), .img_addr(b_img_addr), .img_wdata(b_img_wdata),
        .par_we(b_par_we), .par_addr(b_par_addr), .par_wdata(b_par_wdata),
        .infer_start(b_start), .infer_done(b_done), .busy(b_busy),
        .load_done(b_ldone), .err_ovf(b_err)
    );

    // packed-parameter instance
    logic        p_rst, p_valid, p_done;
    logic [31:0] p_ctrl, p_wdata;
    logic        p_ready, p_img_we, p_par_we, p_start, p_busy, p_ldone, p_err;
    logic [7:0]  p_img_addr;
    logic [31:0] p_img_wdata;
    logic [14:0] p_par_addr;
    logic [7:0]  p_par_wdata;

    npu_load_ctrl #(.IMG_WORDS(8), .PARAM_BYTES(6), .PARAM_PACK(4)) u_pk (
        .clk(clk), .reset(p_rst), .control_reg(p_ctrl),
        .wr_valid(p_valid), .writedata(p_wdata), .wr_ready(p_ready),
        .img_we(p_img_we), .img_addr(p_img_addr), .img_wdata(p_img_wdata),
        .par_we(p_par_we), .par_addr(p_par_addr), .par_wdata(p_par_wdata),
        .infer_start(p_start), .infer_done(p_done), .busy(p_busy),
        .load_done(p_ldone), .err_ovf(p_err)
    );

    // write monitors
    int          b_img_a[$];
    logic [31:0] b_img_d[$];
    int          b_par_a[$];
    logic [7:0]  b_par_d[$];
    int          b_starts = 0;
    int          p_img_a[$];
    logic [31:0] p_img_d[$];
    int          p_par_a[$];
    logic [7:0]  p_par_d[$];

    always @(negedge clk) begin
        if (b_img_we === 1'b1) begin
            b_img_a.push_back(int'(b_img_addr));
            b_img_d.push_back(b_img_wdata);
        end
        if (b_par_we === 1'b1) begin
            b_par_a.push_back(int'(b_par_addr));
            b_par_d.push_back(b_par_wdata);
        end
        if (b_start === 1'b1) b_starts++;
        if (p_img_we === 1'b1) begin
            p_img_a.push_back(int'(p_img_addr));
            p_img_d.push_back(p_img_wdata);
        end
        if (p_par_we === 1'b1) begin
            p_par_a.push_back(int'(p_par_addr));
            p_par_d.push_back(p_par_wdata);
        end
    end

    logic [31:0] b_sent[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b_send(input logic [31:0] d, input int idle_pct);
        while (int'($urandom_range(99)) < idle_pct) begin
            b_valid = 1'b0;
            step();
        end
        b_valid = 1'b1;
        b_wdata = d;
        b_sent.push_back(d);
        step();
    endtask

    // reference: bank k holds byte (3-k), so bank 0 gets the MSB
    function automatic logic [31:0] lanes_of(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
        return r;
    endfunction

    // Number of logged writes disagreeing with the words sent; -1 on count error.
    function automatic int b_diffs(input int ib, input int pb, input int sb,
                                   input int ni, input int np);
        int d;
        logic [31:0] w;
        if (b_img_a.size() - ib != ni) return -1;
        if (b_par_a.size() - pb != np) return -1;
        if (b_sent.size() - sb < ni + np) return -1;
        d = 0;
        for (int i = 0; i < ni; i++) begin
            w = b_sent[sb + i];
            if (b_img_a[ib + i] != i || b_img_d[ib + i] !== lanes_of(w)) d++;
        end
        for (int j = 0; j < np; j++) begin
            w = b_sent[sb + ni + j];
            if (b_par_a[pb + j] != j || b_par_d[pb + j] !== w[7:0]) d++;
        end
        return d;
    endfunction

    task automatic test_reset();
        b_rst = 1'b1; b_ctrl = 32'hDEAD_BEE1; b_valid = 1'b0;
        b_wdata = '0; b_done = 1'b0;
        #2;
        n_cmp++;
        if ({b_ready, b_img_we, b_par_we, b_start, b_busy, b_ldone, b_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0",
                     {b_ready, b_img_we, b_par_we, b_start, b_busy, b_ldone, b_err});
        end
        n_cmp++;
        if ({b_img_addr, b_img_wdata, b_par_addr, b_par_wdata} !== 63'd0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h want 0",
                     {b_img_addr, b_img_wdata, b_par_addr, b_par_wdata});
        end
        repeat (3) @(posedge clk);
        #3 b_rst = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (b_busy !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL held_cmd_at_release: busy %b ready %b want 0 0", b_busy, b_ready);
        end
    endtask

    task automatic test_full_load();
        int ib, pb, sb, d;
        logic [31:0] w0;
        b_ctrl = 32'h0; step();
        b_ctrl = 32'h1; step();
        n_cmp++;
        if (b_busy !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_entry: busy %b ready %b want 1 1", b_busy, b_ready);
        end
        ib = b_img_a.size(); pb = b_par_a.size(); sb = b_sent.size();
        b_send(32'h1122_3344, 0);
        for (int i = 1; i < IMGW + PARB; i++) b_send($urandom, 0);
        b_valid = 1'b0;
        n_cmp++;
        if (b_ldone !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_loaded: load_done %b ready %b want 1 0", b_ldone, b_ready);
        end
        n_cmp++;
        if (b_img_a.size() - ib != IMGW) begin
            n_fail++;
            $display("FAIL b2b_img_count: got %0d want %0d", b_img_a.size() - ib, IMGW);
        end
        n_cmp++;
        if (b_par_a.size() - pb != PARB) begin
            n_fail++;
            $display("FAIL b2b_par_count: got %0d want %0d", b_par_a.size() - pb, PARB);
        end
        w0 = (b_img_d.size() > ib) ? b_img_d[ib] : 32'hx;
        n_cmp++;
        if (w0[7:0] !== 8'h11) begin
            n_fail++;
            $display("FAIL bank0_msb: got %h want 11", w0[7:0]);
        end
        d = b_diffs(ib, pb, sb, IMGW, PARB);
        n_cmp++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL b2b_contents: got %0d bad writes want 0", d);
        end
    endtask

    task automatic test_infer();
        int s0;
        b_done = 1'b1; step(); b_done = 1'b0; step();
        n_cmp++;
        if (b_busy !== 1'b1 || b_ldone !== 1'b1 || b_start !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ignored_loaded: busy %b ld %b st %b want 1 1 0",
                     b_busy, b_ldone, b_start);
        end
        s0 = b_starts;
        b_ctrl = 32'h2; step();
        n_cmp++;
        if (b_start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_pulse: got %b want 1", b_start);
        end
        step();
        n_cmp++;
        if (b_start !== 1'b0 || b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_one_cycle: start %b busy %b want 0 1", b_start, b_busy);
        end
        b_ctrl = 32'h1;
        repeat (48) step();
        n_cmp++;
        if (b_busy !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ignores_load: busy %b ready %b want 1 0", b_busy, b_ready);
        end
        b_done = 1'b1; step(); b_done = 1'b0;
        n_cmp++;
        if (b_busy !== 1'b0 || b_ldone !== 1'b1) begin
            n_fail++;
            $display("FAIL done_state: busy %b ld %b want 0 1", b_busy, b_ldone);
        end
        n_cmp++;
        if (b_starts - s0 != 1) begin
            n_fail++;
            $display("FAIL start_count: got %0d want 1", b_starts - s0);
        end
        repeat (3) step();
        n_cmp++;
        if (b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_cmd_no_reload: busy %b want 0", b_busy);
        end
        b_ctrl = 32'h0; step();
        b_ctrl = 32'h2; step();
        n_cmp++;
        if (b_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_start: got %b want 1", b_start);
        end
        repeat (6) step();
        b_done = 1'b1; step(); b_done = 1'b0;
        n_cmp++;
        if (b_busy !== 1'b0 || b_ldone !== 1'b1 || b_starts - s0 != 2) begin
            n_fail++;
            $display("FAIL rerun_done: busy %b ld %b starts %0d want 0 1 2",
                     b_busy, b_ldone, b_starts - s0);
        end
    endtask

    task automatic test_random_valid();
        int ib, pb, sb, d;
        b_ctrl = 32'h1; step();
        n_cmp++;
        if (b_ldone !== 1'b0 || b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_entry: ld %b busy %b want 0 1", b_ldone, b_busy);
        end
        ib = b_img_a.size(); pb = b_par_a.size(); sb = b_sent.size();
        for (int i = 0; i < IMGW + PARB; i++) b_send($urandom, 30);
        b_valid = 1'b0;
        n_cmp++;
        if (b_ldone !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_loaded: got %b want 1", b_ldone);
        end
        d = b_diffs(ib, pb, sb, IMGW, PARB);
        n_cmp++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL rand_contents: got %0d bad writes want 0", d);
        end
    endtask

    task automatic test_abort();
        int ib;
        b_ctrl = 32'h2; step(); step();
        b_done = 1'b1; step(); b_done = 1'b0;
        b_ctrl = 32'h1; step();
        ib = b_img_a.size();
        for (int i = 0; i < 100; i++) b_send($urandom, 0);
        b_valid = 1'b0;
        b_ctrl = 32'h0; step();
        n_cmp++;
        if (b_busy !== 1'b0 || b_ldone !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy %b ld %b ready %b want 0 0 0",
                     b_busy, b_ldone, b_ready);
        end
        n_cmp++;
        if (b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before: got %b want 0", b_err);
        end
        b_valid = 1'b1; b_wdata = 32'h5A5A_5A5A; step();
        b_valid = 1'b0; step();
        n_cmp++;
        if (b_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b want 1", b_err);
        end
        repeat (5) step();
        n_cmp++;
        if (b_err !== 1'b1 || b_img_a.size() - ib != 100) begin
            n_fail++;
            $display("FAIL err_sticky: err %b img writes %0d want 1 100",
                     b_err, b_img_a.size() - ib);
        end
    endtask

    task automatic test_reset_mid();
        int ib;
        b_ctrl = 32'h1; step();
        for (int i = 0; i < IMGW + 500; i++) b_send($urandom, 0);
        b_wdata = 32'h7777_7777;
        #3 b_rst = 1'b1;
        #1;
        n_cmp++;
        if ({b_ready, b_img_we, b_par_we, b_start, b_busy, b_ldone, b_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_flags: got %b want 0",
                     {b_ready, b_img_we, b_par_we, b_start, b_busy, b_ldone, b_err});
        end
        n_cmp++;
        if ({b_img_addr, b_img_wdata, b_par_addr, b_par_wdata} !== 63'd0) begin
            n_fail++;
            $display("FAIL async_reset_buses: got %h want 0",
                     {b_img_addr, b_img_wdata, b_par_addr, b_par_wdata});
        end
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 b_rst = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trigger_after_reset: busy %b want 0", b_busy);
        end
        b_ctrl = 32'h0; step();
        b_ctrl = 32'h1; step();
        n_cmp++;
        if (b_img_addr !== 8'd0 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_addr: addr %0d ready %b want 0 1", b_img_addr, b_ready);
        end
        ib = b_img_a.size();
        b_send(32'hCAFE_F00D, 0);
        b_valid = 1'b0;
        n_cmp++;
        if (b_img_a.size() != ib + 1 || b_img_a[ib] != 0) begin
            n_fail++;
            $display("FAIL restart_first_write: writes %0d want 1 at addr 0",
                     b_img_a.size() - ib);
        end
    endtask

    task automatic test_pack();
        logic [31:0] pw[2];
        logic [7:0]  eb[$];
        logic [31:0] w;
        int idx, low, cyc, d;
        pw[0] = 32'hAABB_CCDD;
        pw[1] = {16'h1122, 16'($urandom)};
        for (int i = 0; i < 2; i++) begin
            w = pw[i];
            for (int b = 3; b >= 0; b--) eb.push_back(w[8*b +: 8]);
        end
        p_rst = 1'b1; p_ctrl = 32'h0; p_valid = 1'b0; p_wdata = '0; p_done = 1'b0;
        repeat (2) @(posedge clk);
        #3 p_rst = 1'b0;
        step();
        p_ctrl = 32'h1; step();
        for (int i = 0; i < 8; i++) begin
            p_valid = 1'b1; p_wdata = 32'h1122_3344 + i; step();
        end
        idx = 0; low = 0; cyc = 0;
        while (idx < 2 && cyc < 20) begin
            p_valid = 1'b1; p_wdata = pw[idx];
            @(negedge clk);
            if (p_ready === 1'b1) idx++;
            else if (idx == 1) low++;
            step();
            cyc++;
        end
        p_valid = 1'b0;
        n_cmp++;
        if (idx != 2) begin
            n_fail++;
            $display("FAIL pack_timeout: accepted %0d want 2", idx);
        end
        n_cmp++;
        if (low != 3) begin
            n_fail++;
            $display("FAIL pack_ready_low: got %0d want 3", low);
        end
        step();
        n_cmp++;
        if (p_ldone !== 1'b1 || p_busy !== 1'b1 || p_start !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_loaded: ld %b busy %b st %b want 1 1 0",
                     p_ldone, p_busy, p_start);
        end
        repeat (3) step();
        d = 0;
        if (p_par_a.size() != 6) d = -1;
        else for (int j = 0; j < 6; j++)
            if (p_par_a[j] != j || p_par_d[j] !== eb[j]) d++;
        n_cmp++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL pack_bytes: got %0d bad (count %0d) want 0 of 6",
                     d, p_par_a.size());
        end
        n_cmp++;
        if (p_img_a.size() != 8 || p_img_d[0] !== lanes_of(32'h1122_3344)
            || p_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_img: count %0d err %b want 8 0", p_img_a.size(), p_err);
        end
    endtask

    initial begin
        p_rst = 1'b1; p_ctrl = '0; p_valid = 1'b0; p_wdata = '0; p_done = 1'b0;
        test_reset();
        test_full_load();
        test_infer();
        test_random_valid();
        test_abort();
        test_reset_mid();
        test_pack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
